// File: rtl/cmi_pkg.sv
// cmi_pkg: shared types and constants for the CMI link controller.
//   - cmi_state_e   : alignment FSM state (HUNT / LOCK)
//   - CODE_*        : CMI code-pair values
//   - *_W           : counter widths
//   - cmi_is_viol   : violation rule for one code pair
//   - cmi_decode    : code pair -> decoded bit
package cmi_pkg;

  typedef enum logic [0:0] {
    HUNT = 1'b0,
    LOCK = 1'b1
  } cmi_state_e;

  localparam logic [1:0] CODE_ZERO    = 2'b01;
  localparam logic [1:0] CODE_MARK_P  = 2'b11;
  localparam logic [1:0] CODE_MARK_N  = 2'b00;
  localparam logic [1:0] CODE_ILLEGAL = 2'b10;

  localparam int DIV_W  = 16;
  localparam int GOOD_W = 8;
  localparam int ERR_W  = 4;
  localparam int VIOL_W = 8;

  // 10 is never legal; a mark must have the opposite polarity of the last mark.
  function automatic logic cmi_is_viol(input logic [1:0] pair, input logic last_mark);
    logic v;
    v = 1'b0;
    case (pair)
      CODE_ILLEGAL: v = 1'b1;
      CODE_MARK_P:  v = (last_mark == 1'b1);
      CODE_MARK_N:  v = (last_mark == 1'b0);
      default:      v = 1'b0;
    endcase
    return v;
  endfunction

  // 00/11 -> 1, 01/10 -> 0
  function automatic logic cmi_decode(input logic [1:0] pair);
    return (pair == CODE_MARK_P) || (pair == CODE_MARK_N);
  endfunction

endpackage

// File: rtl/cmi_link_ctrl_tick.sv
// cmi_tick_gen: half-bit / bit strobe generator.
//   i_clk, i_rst_n (sync, active-low), i_en (freeze when 0)
//   o_half_tick : 1 cycle at the end of each half-bit (count == DIV-1)
//   o_bit_tick  : half tick that closes the second half of a bit
//   o_ser_sel   : current half (0 = first, 1 = second), registered
module cmi_tick_gen
  import cmi_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  output logic o_half_tick,
  output logic o_bit_tick,
  output logic o_ser_sel
);

  localparam logic [DIV_W-1:0] CNT_LAST = DIV_W'(DIV - 1);

  logic [DIV_W-1:0] r_cnt;
  logic             r_half_phase;
  logic             w_half_tick;

  assign w_half_tick = i_en && (r_cnt == CNT_LAST);
  assign o_half_tick = w_half_tick;
  assign o_bit_tick  = w_half_tick && r_half_phase;
  assign o_ser_sel   = r_half_phase;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt        <= '0;
      r_half_phase <= 1'b0;
    end else if (i_en) begin
      if (r_cnt == CNT_LAST) begin
        r_cnt        <= '0;
        r_half_phase <= ~r_half_phase;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/cmi_link_ctrl.sv
// cmi_link_ctrl: CMI timing and receive-alignment controller.
//   clk_sig, reset_sig (sync, active-low), en_sig (run enable)
//   rx_serial_sig : serial CMI line, one code half per half-bit
//   half_tick_sig, bit_tick_sig, ser_sel_sig : pacing for source/encoder/serializer
//   dec_valid_sig, dec_bit_sig : decoded bit strobe (LOCK only)
//   locked_sig    : FSM in LOCK
//   viol_cnt_sig  : saturating count of violations seen in LOCK
module cmi_link_ctrl
  import cmi_pkg::*;
#(
  parameter int DIV       = 4,
  parameter int LOCK_CNT  = 8,
  parameter int ERR_LIMIT = 3
) (
  input  logic       clk_sig,
  input  logic       reset_sig,
  input  logic       en_sig,
  input  logic       rx_serial_sig,
  output logic       half_tick_sig,
  output logic       bit_tick_sig,
  output logic       ser_sel_sig,
  output logic       dec_valid_sig,
  output logic       dec_bit_sig,
  output logic       locked_sig,
  output logic [7:0] viol_cnt_sig
);

  localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_CNT - 1);
  localparam logic [ERR_W-1:0]  ERR_LAST  = ERR_W'(ERR_LIMIT - 1);

  logic              w_half_tick;
  logic              w_ser_sel;
  logic              w_eval;
  logic              w_viol;
  logic [1:0]        w_pair;

  cmi_state_e        r_state;
  logic              r_cur;
  logic              r_align;
  logic              r_last_mark;
  logic [GOOD_W-1:0] r_good;
  logic [ERR_W-1:0]  r_err;
  logic [VIOL_W-1:0] r_viol;
  logic              r_dec_valid;
  logic              r_dec_bit;

  cmi_tick_gen #(.DIV(DIV)) u_tick (
    .i_clk       (clk_sig),
    .i_rst_n     (reset_sig),
    .i_en        (en_sig),
    .o_half_tick (w_half_tick),
    .o_bit_tick  (bit_tick_sig),
    .o_ser_sel   (w_ser_sel)
  );

  // Pair formed at this tick: previous half sample plus the half being
  // sampled now. A pair is judged when the tick moves half_phase onto
  // align, so with align=0 pairs close on bit_tick (first half, second half).
  assign w_pair = {r_cur, rx_serial_sig};
  assign w_eval = w_half_tick && (w_ser_sel != r_align);
  assign w_viol = cmi_is_viol(w_pair, r_last_mark);

  assign half_tick_sig = w_half_tick;
  assign ser_sel_sig   = w_ser_sel;
  assign dec_valid_sig = r_dec_valid && en_sig;
  assign dec_bit_sig   = r_dec_bit;
  assign locked_sig    = (r_state == LOCK);
  assign viol_cnt_sig  = r_viol;

  always_ff @(posedge clk_sig) begin
    if (!reset_sig) begin
      r_state     <= HUNT;
      r_cur       <= 1'b0;
      r_align     <= 1'b0;
      r_last_mark <= 1'b0;
      r_good      <= '0;
      r_err       <= '0;
      r_viol      <= '0;
      r_dec_valid <= 1'b0;
      r_dec_bit   <= 1'b0;
    end else begin
      r_dec_valid <= 1'b0;
      if (w_half_tick) r_cur <= rx_serial_sig;
      if (w_eval) begin
        // only legal marks move the alternation reference
        if (!w_viol && (w_pair[1] == w_pair[0])) r_last_mark <= w_pair[1];
        unique case (r_state)
          HUNT: begin
            if (w_viol) begin
              r_align <= ~r_align;
              r_good  <= '0;
            end else if (r_good == GOOD_LAST) begin
              r_state <= LOCK;
              r_good  <= '0;
              r_err   <= '0;
            end else begin
              r_good <= r_good + 1'b1;
            end
          end
          LOCK: begin
            // violating pairs are still delivered downstream
            r_dec_valid <= 1'b1;
            r_dec_bit   <= cmi_decode(w_pair);
            if (w_viol) begin
              if (r_viol != {VIOL_W{1'b1}}) r_viol <= r_viol + 1'b1;
              if (r_err == ERR_LAST) begin
                r_state <= HUNT;
                r_align <= ~r_align;
                r_good  <= '0;
                r_err   <= '0;
              end else begin
                r_err <= r_err + 1'b1;
              end
            end else begin
              r_err <= '0;
            end
          end
          default: r_state <= HUNT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cmi_link_ctrl.sv
module tb_cmi_link_ctrl;

  logic       clk_sig = 1'b0;
  logic       reset_sig = 1'b0;
  logic       en_sig = 1'b0;
  logic       rx_serial_sig = 1'b0;
  logic       half_tick_sig, bit_tick_sig, ser_sel_sig;
  logic       dec_valid_sig, dec_bit_sig, locked_sig;
  logic [7:0] viol_cnt_sig;

  int   checks = 0;
  int   failures = 0;
  logic exp_q[$];

  cmi_link_ctrl #(.DIV(4), .LOCK_CNT(8), .ERR_LIMIT(3)) dut (
    .clk_sig       (clk_sig),
    .reset_sig     (reset_sig),
    .en_sig        (en_sig),
    .rx_serial_sig (rx_serial_sig),
    .half_tick_sig (half_tick_sig),
    .bit_tick_sig  (bit_tick_sig),
    .ser_sel_sig   (ser_sel_sig),
    .dec_valid_sig (dec_valid_sig),
    .dec_bit_sig   (dec_bit_sig),
    .locked_sig    (locked_sig),
    .viol_cnt_sig  (viol_cnt_sig)
  );

  always #5 clk_sig = ~clk_sig;

  // CMI decode table: 01 -> 0, 10 -> 0, 00/11 -> 1
  function automatic logic ref_decode(input logic [1:0] p);
    logic b;
    case (p)
      2'b01:   b = 1'b0;
      2'b10:   b = 1'b0;
      default: b = 1'b1;
    endcase
    return b;
  endfunction

  // scoreboard pop: called on every falling edge while stimulus runs
  task automatic scan_dec();
    logic e;
    if (dec_valid_sig === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL dec_unexpected got_bit=%0b want=no_dec_valid", dec_bit_sig);
      end else begin
        e = exp_q.pop_front();
        if (dec_bit_sig !== e) begin
          failures++;
          $display("FAIL dec_bit got=%0b want=%0b", dec_bit_sig, e);
        end
      end
    end
  endtask

  // hold one code half on the line through the next half_tick edge
  task automatic send_half(input logic b);
    int n;
    n = 0;
    rx_serial_sig = b;
    forever begin
      @(negedge clk_sig);
      scan_dec();
      if (half_tick_sig === 1'b1) break;
      n++;
      if (n > 20) begin
        checks++;
        failures++;
        $display("FAIL half_tick_timeout got=none want=tick_within_20");
        break;
      end
    end
    @(posedge clk_sig);
    #1;
  endtask

  task automatic send_pair(input logic [1:0] p, input logic push);
    if (push) exp_q.push_back(ref_decode(p));
    send_half(p[1]);
    send_half(p[0]);
  endtask

  task automatic drain(input string tag);
    repeat (3) begin
      @(negedge clk_sig);
      scan_dec();
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_missing_dec got_pending=%0d want=0", tag, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic do_reset();
    reset_sig = 1'b0;
    en_sig = 1'b1;
    rx_serial_sig = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk_sig);
    #1;
    reset_sig = 1'b1;
  endtask

  // eight aligned 01 pairs; lock must appear exactly on the 8th
  task automatic lock_zeros(input string tag);
    for (int i = 0; i < 8; i++) begin
      send_pair(2'b01, 1'b0);
      if (i == 6) begin
        checks++;
        if (locked_sig !== 1'b0) begin
          failures++;
          $display("FAIL %s_early_lock got=%0b want=0", tag, locked_sig);
        end
      end
    end
    checks++;
    if (locked_sig !== 1'b1) begin
      failures++;
      $display("FAIL %s_lock got=%0b want=1", tag, locked_sig);
    end
  endtask

  task automatic test_reset();
    reset_sig = 1'b0;
    en_sig = 1'b1;
    rx_serial_sig = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk_sig);
      #1;
      checks++;
      if ({half_tick_sig, bit_tick_sig, ser_sel_sig, dec_valid_sig, locked_sig, viol_cnt_sig} !== 13'd0) begin
        failures++;
        $display("FAIL reset_outputs got=%b_%b_%b_%b_%b_%0d want=all_zero", half_tick_sig,
                 bit_tick_sig, ser_sel_sig, dec_valid_sig, locked_sig, viol_cnt_sig);
      end
    end
  endtask

  task automatic test_ticks();
    logic eh, eb, es;
    do_reset();
    for (int c = 1; c <= 24; c++) begin
      @(negedge clk_sig);
      eh = (c % 4 == 0);
      eb = (c % 8 == 0);
      es = logic'(((c - 1) / 4) % 2);
      checks += 3;
      if (half_tick_sig !== eh) begin
        failures++;
        $display("FAIL half_tick c=%0d got=%0b want=%0b", c, half_tick_sig, eh);
      end
      if (bit_tick_sig !== eb) begin
        failures++;
        $display("FAIL bit_tick c=%0d got=%0b want=%0b", c, bit_tick_sig, eb);
      end
      if (ser_sel_sig !== es) begin
        failures++;
        $display("FAIL ser_sel c=%0d got=%0b want=%0b", c, ser_sel_sig, es);
      end
    end
  endtask

  task automatic test_enable();
    do_reset();
    repeat (2) @(posedge clk_sig);
    #1;
    en_sig = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_sig);
      checks++;
      if (half_tick_sig !== 1'b0) begin
        failures++;
        $display("FAIL en_freeze_tick i=%0d got=%0b want=0", i, half_tick_sig);
      end
    end
    @(posedge clk_sig);
    #1;
    en_sig = 1'b1;
    @(negedge clk_sig);
    checks++;
    if (half_tick_sig !== 1'b0) begin
      failures++;
      $display("FAIL en_resume_early got=%0b want=0", half_tick_sig);
    end
    @(negedge clk_sig);
    checks++;
    if (half_tick_sig !== 1'b1) begin
      failures++;
      $display("FAIL en_resume_tick got=%0b want=1", half_tick_sig);
    end
  endtask

  task automatic test_lock_zeros();
    do_reset();
    lock_zeros("zeros");
    for (int i = 0; i < 4; i++) send_pair(2'b01, 1'b1);
    drain("zeros");
    checks++;
    if (viol_cnt_sig !== 8'd0) begin
      failures++;
      $display("FAIL zeros_viol got=%0d want=0", viol_cnt_sig);
    end
  endtask

  task automatic test_slip();
    logic [1:0] pre[8];
    logic [1:0] post[4];
    pre  = '{2'b01, 2'b11, 2'b01, 2'b00, 2'b01, 2'b11, 2'b00, 2'b01};
    post = '{2'b11, 2'b01, 2'b00, 2'b01};
    do_reset();
    // a stray leading 1 makes the first judged pair 10
    send_half(1'b1);
    for (int i = 0; i < 8; i++) begin
      send_pair(pre[i], 1'b0);
      if (i == 6) begin
        checks++;
        if (locked_sig !== 1'b0) begin
          failures++;
          $display("FAIL slip_early_lock got=%0b want=0", locked_sig);
        end
      end
    end
    checks++;
    if (locked_sig !== 1'b1) begin
      failures++;
      $display("FAIL slip_lock got=%0b want=1", locked_sig);
    end
    for (int i = 0; i < 4; i++) send_pair(post[i], 1'b1);
    drain("slip");
    checks++;
    if (viol_cnt_sig !== 8'd0) begin
      failures++;
      $display("FAIL slip_viol got=%0d want=0", viol_cnt_sig);
    end
  endtask

  task automatic test_err_unlock();
    do_reset();
    lock_zeros("unlock");
    for (int i = 1; i <= 3; i++) begin
      send_pair(2'b10, 1'b1);
      checks += 2;
      if (viol_cnt_sig !== 8'(i)) begin
        failures++;
        $display("FAIL unlock_viol n=%0d got=%0d want=%0d", i, viol_cnt_sig, i);
      end
      if (locked_sig !== (i < 3)) begin
        failures++;
        $display("FAIL unlock_locked n=%0d got=%0b want=%0b", i, locked_sig, (i < 3));
      end
    end
    // align flipped: pairs now close on the other half, so a lone half
    // completes a legal 01 with the trailing 0 of the last 10
    send_half(1'b1);
    for (int i = 0; i < 7; i++) begin
      send_pair(2'b01, 1'b0);
      if (i == 5) begin
        checks++;
        if (locked_sig !== 1'b0) begin
          failures++;
          $display("FAIL unlock_early_relock got=%0b want=0", locked_sig);
        end
      end
    end
    checks++;
    if (locked_sig !== 1'b1) begin
      failures++;
      $display("FAIL unlock_relock got=%0b want=1", locked_sig);
    end
    drain("unlock");
  endtask

  task automatic test_mark_repeat();
    do_reset();
    lock_zeros("mark");
    send_pair(2'b11, 1'b1);
    send_pair(2'b11, 1'b1);
    checks += 2;
    if (viol_cnt_sig !== 8'd1) begin
      failures++;
      $display("FAIL mark_viol got=%0d want=1", viol_cnt_sig);
    end
    if (locked_sig !== 1'b1) begin
      failures++;
      $display("FAIL mark_locked got=%0b want=1", locked_sig);
    end
    send_pair(2'b01, 1'b1);
    // err must have been cleared, so two more violations keep lock
    send_pair(2'b10, 1'b1);
    send_pair(2'b10, 1'b1);
    checks += 2;
    if (viol_cnt_sig !== 8'd3) begin
      failures++;
      $display("FAIL mark_viol3 got=%0d want=3", viol_cnt_sig);
    end
    if (locked_sig !== 1'b1) begin
      failures++;
      $display("FAIL mark_err_clear got=%0b want=1", locked_sig);
    end
    send_pair(2'b01, 1'b1);
    drain("mark");
  endtask

  task automatic test_reset_mid_lock();
    do_reset();
    lock_zeros("rstlock");
    send_pair(2'b10, 1'b1);
    @(negedge clk_sig);
    scan_dec();
    reset_sig = 1'b0;
    @(posedge clk_sig);
    #1;
    checks++;
    if ({half_tick_sig, bit_tick_sig, ser_sel_sig, dec_valid_sig, locked_sig, viol_cnt_sig} !== 13'd0) begin
      failures++;
      $display("FAIL rstlock_outputs got=%b_%b_%b_%b_%b_%0d want=all_zero", half_tick_sig,
               bit_tick_sig, ser_sel_sig, dec_valid_sig, locked_sig, viol_cnt_sig);
    end
    reset_sig = 1'b1;
    lock_zeros("rstlock_relock");
    drain("rstlock");
  endtask

  initial begin
    test_reset();
    test_ticks();
    test_enable();
    test_lock_zeros();
    test_slip();
    test_err_unlock();
    test_mark_repeat();
    test_reset_mid_lock();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
